// File: rtl/pic_axi_lite_prio_pkg.sv
// Shared constants and types for the priority interrupt controller:
// CSR offsets, AXI response codes, priority type and channel state encodings.
package pic_axi_lite_prio_pkg;

  localparam int unsigned PRIO_W = 3;
  typedef logic [PRIO_W-1:0] prio_t;

  localparam logic [11:0] CSR_CTRL      = 12'h000;
  localparam logic [11:0] CSR_ENABLE    = 12'h004;
  localparam logic [11:0] CSR_MODE      = 12'h008;
  localparam logic [11:0] CSR_PENDING   = 12'h00C;
  localparam logic [11:0] CSR_THRESHOLD = 12'h010;
  localparam logic [11:0] CSR_CLAIM     = 12'h014;
  localparam logic [11:0] CSR_INSERVICE = 12'h018;
  localparam logic [11:0] CSR_PRIO_BASE = 12'h100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_e;

endpackage

// File: rtl/pic_prio_arbiter.sv
// Picks the highest-priority eligible source (lowest index on ties) and
// registers its id (index+1, 0 = none) together with a valid flag.
module pic_prio_arbiter #(
  parameter int unsigned NUM_IRQ = 16,
  parameter int unsigned PRIO_W  = 3,
  parameter int unsigned ID_W    = 5
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_IRQ-1:0]        eligible,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio,
  output logic [ID_W-1:0]           winner_id,
  output logic                      winner_valid
);

  logic [PRIO_W-1:0] best_prio;
  logic [ID_W-1:0]   best_id;
  logic              found;

  // Strict greater-than keeps the earlier (lower) index on equal priority.
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i] && (!found || prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = prio[i*PRIO_W +: PRIO_W];
        best_id   = ID_W'(i + 1);
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      winner_id    <= '0;
      winner_valid <= 1'b0;
    end else begin
      winner_id    <= best_id;
      winner_valid <= found;
    end
  end

endmodule

// File: rtl/pic_axi_lite_prio.sv
// AXI4-Lite priority interrupt controller with claim/complete protocol.
// Define PIC_IRQ_SYNC_EN to pass irq through a 2-flop synchroniser.
module pic_axi_lite_prio #(
  parameter int unsigned NUM_IRQ = 16,
  parameter int unsigned PRIO_W  = pic_axi_lite_prio_pkg::PRIO_W
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [31:0]        s_axi_lite_awaddr,
  input  logic               s_axi_lite_awvalid,
  output logic               s_axi_lite_awready,
  input  logic [31:0]        s_axi_lite_wdata,
  input  logic               s_axi_lite_wvalid,
  output logic               s_axi_lite_wready,
  output logic [1:0]         s_axi_lite_bresp,
  output logic               s_axi_lite_bvalid,
  input  logic               s_axi_lite_bready,
  input  logic [31:0]        s_axi_lite_araddr,
  input  logic               s_axi_lite_arvalid,
  output logic               s_axi_lite_arready,
  output logic [31:0]        s_axi_lite_rdata,
  output logic [1:0]         s_axi_lite_rresp,
  output logic               s_axi_lite_rvalid,
  input  logic               s_axi_lite_rready,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               interrupt
);
  import pic_axi_lite_prio_pkg::*;

  localparam int unsigned ID_W = $clog2(NUM_IRQ + 1);

  wr_state_e wstate_q, wstate_n;
  rd_state_e rstate_q, rstate_n;

  logic                      ctrl_en_q;
  logic [NUM_IRQ-1:0]        enable_q, mode_q, pending_q, inservice_q, irq_q;
  logic [NUM_IRQ-1:0]        pending_n, inservice_n, eligible, irq_s, irq_rise;
  logic [NUM_IRQ-1:0]        w1c_mask, complete_mask, claim_mask;
  logic [PRIO_W-1:0]         thresh_q;
  logic [NUM_IRQ*PRIO_W-1:0] prio_q;
  logic [ID_W-1:0]           winner_id, claim_id;
  logic                      winner_valid;
  logic                      do_write, do_read, wr_ok;
  logic [31:0]               rd_data, rdata_q;
  logic [1:0]                rd_resp, rresp_q, bresp_q;
  logic [11:0]               waddr, raddr;
  logic                      unused_addr_bits;

  assign waddr            = s_axi_lite_awaddr[11:0];
  assign raddr            = s_axi_lite_araddr[11:0];
  assign unused_addr_bits = ^{s_axi_lite_awaddr[31:12], s_axi_lite_araddr[31:12]};

  function automatic logic [11:0] prio_addr(input int unsigned idx);
    return CSR_PRIO_BASE + 12'(idx * 4);
  endfunction

`ifdef PIC_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;
  always_ff @(posedge aclk) begin
    if (areset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end
  assign irq_s = sync2_q;
`else
  assign irq_s = irq;
`endif

  // Channel state registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
    end else begin
      wstate_q <= wstate_n;
      rstate_q <= rstate_n;
    end
  end

  always_comb begin
    wstate_n = wstate_q;
    case (wstate_q)
      W_IDLE:  if (s_axi_lite_awvalid && s_axi_lite_wvalid) wstate_n = W_ACK;
      W_ACK:   wstate_n = (s_axi_lite_awvalid && s_axi_lite_wvalid) ? W_RESP : W_IDLE;
      W_RESP:  if (s_axi_lite_bready) wstate_n = W_IDLE;
      default: wstate_n = W_IDLE;
    endcase
    rstate_n = rstate_q;
    case (rstate_q)
      R_IDLE:  if (s_axi_lite_arvalid) rstate_n = R_ACK;
      R_ACK:   rstate_n = s_axi_lite_arvalid ? R_DATA : R_IDLE;
      R_DATA:  if (s_axi_lite_rready) rstate_n = R_IDLE;
      default: rstate_n = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_lite_awready = (wstate_q == W_ACK);
    s_axi_lite_wready  = (wstate_q == W_ACK);
    s_axi_lite_bvalid  = (wstate_q == W_RESP);
    s_axi_lite_arready = (rstate_q == R_ACK);
    s_axi_lite_rvalid  = (rstate_q == R_DATA);
    s_axi_lite_bresp   = bresp_q;
    s_axi_lite_rdata   = rdata_q;
    s_axi_lite_rresp   = rresp_q;
  end

  assign do_write = (wstate_q == W_ACK) && s_axi_lite_awvalid && s_axi_lite_wvalid;
  assign do_read  = (rstate_q == R_ACK) && s_axi_lite_arvalid;

  // Interrupt bookkeeping
  always_comb begin
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      eligible[i] = ctrl_en_q && enable_q[i] && pending_q[i] && !inservice_q[i]
                    && (prio_q[i*PRIO_W +: PRIO_W] > thresh_q);
    end
  end

  always_comb begin
    w1c_mask      = '0;
    complete_mask = '0;
    claim_mask    = '0;
    claim_id      = '0;
    if (do_write && waddr == CSR_PENDING) w1c_mask = s_axi_lite_wdata[NUM_IRQ-1:0] & mode_q;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (do_write && waddr == CSR_CLAIM && s_axi_lite_wdata == 32'(i + 1)) complete_mask[i] = 1'b1;
      // The winner is a cycle old, so re-check it is still eligible before claiming.
      if (do_read && raddr == CSR_CLAIM && winner_valid && winner_id == ID_W'(i + 1) && eligible[i]) begin
        claim_mask[i] = 1'b1;
        claim_id      = winner_id;
      end
    end
  end

  assign irq_rise    = irq_s & ~irq_q;
  assign pending_n   = (mode_q & ((pending_q & ~(w1c_mask | claim_mask)) | irq_rise))
                     | (~mode_q & irq_s & ~inservice_q);
  assign inservice_n = (inservice_q & ~complete_mask) | claim_mask;

  always_comb begin
    wr_ok = 1'b0;
    case (waddr)
      CSR_CTRL, CSR_ENABLE, CSR_MODE, CSR_PENDING,
      CSR_THRESHOLD, CSR_CLAIM, CSR_INSERVICE: wr_ok = 1'b1;
      default: for (int unsigned i = 0; i < NUM_IRQ; i++) if (waddr == prio_addr(i)) wr_ok = 1'b1;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (raddr)
      CSR_CTRL:      rd_data[0]           = ctrl_en_q;
      CSR_ENABLE:    rd_data[NUM_IRQ-1:0] = enable_q;
      CSR_MODE:      rd_data[NUM_IRQ-1:0] = mode_q;
      CSR_PENDING:   rd_data[NUM_IRQ-1:0] = pending_q;
      CSR_THRESHOLD: rd_data[PRIO_W-1:0]  = thresh_q;
      CSR_CLAIM:     rd_data[ID_W-1:0]    = claim_id;
      CSR_INSERVICE: rd_data[NUM_IRQ-1:0] = inservice_q;
      default: begin
        rd_resp = RESP_SLVERR;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
          if (raddr == prio_addr(i)) begin
            rd_data[PRIO_W-1:0] = prio_q[i*PRIO_W +: PRIO_W];
            rd_resp             = RESP_OKAY;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ctrl_en_q   <= 1'b0;
      enable_q    <= '0;
      mode_q      <= '0;
      pending_q   <= '0;
      inservice_q <= '0;
      irq_q       <= '0;
      thresh_q    <= '0;
      prio_q      <= '0;
      bresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
    end else begin
      irq_q       <= irq_s;
      pending_q   <= pending_n;
      inservice_q <= inservice_n;
      if (do_write) begin
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        case (waddr)
          CSR_CTRL:      ctrl_en_q <= s_axi_lite_wdata[0];
          CSR_ENABLE:    enable_q  <= s_axi_lite_wdata[NUM_IRQ-1:0];
          CSR_MODE:      mode_q    <= s_axi_lite_wdata[NUM_IRQ-1:0];
          CSR_THRESHOLD: thresh_q  <= s_axi_lite_wdata[PRIO_W-1:0];
          default: ;
        endcase
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
          if (waddr == prio_addr(i)) prio_q[i*PRIO_W +: PRIO_W] <= s_axi_lite_wdata[PRIO_W-1:0];
        end
      end
      if (do_read) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  pic_prio_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W)
  ) u_arbiter (
    .aclk         (aclk),
    .areset       (areset),
    .eligible     (eligible),
    .prio         (prio_q),
    .winner_id    (winner_id),
    .winner_valid (winner_valid)
  );

  assign interrupt = winner_valid;

endmodule

// File: doc/pic_axi_lite_prio.md
Name: pic_axi_lite_prio

Overview:
- Parametrised programmable interrupt controller with an AXI4-Lite slave CSR port, `NUM_IRQ` sources and per-source edge/level mode.
- Adds per-source priority, a priority threshold and a claim/complete protocol on top of the plain mask/pending behaviour.
- Sits between peripheral IRQ lines and the RISC-V core's external interrupt input.

Parameters:
- NUM_IRQ, 16, number of interrupt sources, legal 1..31.
- PRIO_W, 3, priority field width; priority 0 means never interrupt.

Ports:
- aclk  input  1  clock, all logic on rising edge
- areset  input  1  synchronous, active-high reset
- s_axi_lite_awaddr  input  32  write address
- s_axi_lite_awvalid/awready  in/out  1  write address handshake
- s_axi_lite_wdata  input  32  write data
- s_axi_lite_wvalid/wready  in/out  1  write data handshake
- s_axi_lite_bresp  output  2  write response
- s_axi_lite_bvalid/bready  out/in  1  write response handshake
- s_axi_lite_araddr  input  32  read address
- s_axi_lite_arvalid/arready  in/out  1  read address handshake
- s_axi_lite_rdata  output  32  read data
- s_axi_lite_rresp  output  2  read response
- s_axi_lite_rvalid/rready  out/in  1  read data handshake
- irq  input  NUM_IRQ  interrupt request lines
- interrupt  output  1  registered request to the core

Behaviour:
- Reset: all ready/valid outputs 0, bresp/rresp 0, rdata 0, interrupt 0. All CSRs 0: disabled, level mode, priority 0, threshold 0, nothing pending or in service.
- CSR map (byte offsets, address bits [11:0] decoded):
  - 0x00 CTRL: bit0 global enable.
  - 0x04 ENABLE: mask.
  - 0x08 MODE: 1 = edge.
  - 0x0C PENDING: read-only view; write-1-to-clear for edge sources only.
  - 0x10 THRESHOLD.
  - 0x14 CLAIM/COMPLETE.
  - 0x18 INSERVICE: read-only.
  - 0x100+4*i PRIO[i].
- Any other offset returns SLVERR (2'b10) with rdata 0; writes to it have no effect.
- Write handshake: accepted only when awvalid and wvalid are both high and no response is outstanding. awready and wready pulse together for exactly one cycle. bvalid rises the next cycle and holds until bready.
- Read handshake: arready pulses for one cycle. rvalid rises the next cycle with data and holds until rready.
- Outstanding transactions: one write and one read may be outstanding at once.
- Edge sources: irq is registered every cycle; a 0->1 transition sets pending.
- Level sources: pending equals irq while the source is not in service.
- Eligibility: enabled, pending, not in service, PRIO > THRESHOLD, and CTRL.0 = 1.
- Arbitration: highest PRIO among eligible sources wins; ties go to the lowest index.
- Winner register: winner id (index+1, 0 = none) and interrupt are registered, so an input change appears on interrupt 2 cycles after an irq edge.
- CLAIM read: returns the winner id at the cycle rvalid rises. Sets that source's in-service bit and clears its pending bit if it is an edge source. Returns 0 with no side effect if no source is eligible.
- COMPLETE write: writing id to 0x14 clears in-service for that id. Ids of 0 or above NUM_IRQ are ignored and still return OKAY.
- Simultaneous events:
  - An edge in the same cycle as a W1C clear or a claim leaves pending set.
  - A COMPLETE and a CLAIM landing in the same cycle are both applied.
- Reset mid-transaction: the handshake is dropped; no response is issued after areset.

Optional Feature:
- Macro PIC_IRQ_SYNC_EN.
- Defined: irq passes through a 2-flop synchroniser before edge/level logic, adding 2 cycles of latency (4 cycles from irq to interrupt).
- Undefined: irq is sampled directly; latency as stated in Behaviour.

Decomposition:
- Package pic_axi_lite_prio_pkg holds:
  - CSR offset localparams (CSR_CTRL, CSR_ENABLE, CSR_MODE, CSR_PENDING, CSR_THRESHOLD, CSR_CLAIM, CSR_INSERVICE, CSR_PRIO_BASE);
  - AXI response codes RESP_OKAY / RESP_SLVERR;
  - typedef prio_t as logic [PRIO_W-1:0], with PRIO_W exported from the package default.
- Sub-module pic_prio_arbiter: eligible vector plus priorities in, registered winner id and valid out. It contains the compare tree.

Test Plan:
- Reset, then read every CSR -> all 0, OKAY. Read 0x04C -> SLVERR, rdata 0.
- Source 3 edge, PRIO 5, enabled, THRESHOLD 2, CTRL 1. Pulse irq[3] -> interrupt high 2 cycles later. CLAIM reads 4 and interrupt drops. COMPLETE 4 clears in-service.
- Sources 2 and 7 both pending, PRIO 4 and 6 -> CLAIM returns 8 then 3. Equal priorities -> lower index returned first.
- PRIO 2 with THRESHOLD 2 -> interrupt stays 0. Lower THRESHOLD to 1 -> interrupt high.
- Level source held high after COMPLETE -> re-claimable. Edge on a claimed source -> pending set again, not claimable until COMPLETE.
- areset asserted while bvalid is high and bready is low -> bvalid 0 the next cycle, all CSRs 0.
